// File: rtl/irrigation_scheduler.sv
// Tank/soil driven drip and sprinkler scheduler with debounced sensors.
// Build option DISP_AUTO_TOGGLE_EN: free-running display toggle instead of S.
module irrigation_scheduler #(
  parameter int DEB_CYC  = 4,
  parameter int MIN_ON   = 16,
  parameter int MAX_ON   = 64,
  parameter int COOL_CYC = 8,
  parameter int DISP_CYC = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Ua,
  input  logic       Us,
  input  logic       T,
  input  logic       S,
  output logic       Bs,
  output logic       Vs,
  output logic       E,
  output logic       Al,
  output logic       tout,
  output logic       disp_sel,
  output logic [2:0] state
);

  localparam int RW = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;
  localparam int CW = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_ON - 1);
  localparam logic [RW-1:0] RUN_MIN  = RW'(MIN_ON - 1);
  localparam logic [CW-1:0] COOL_END = CW'(COOL_CYC - 1);
  localparam logic [DW-1:0] DEB_END  = DW'(DEB_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIP  = 3'd1,
    SPRAY = 3'd2,
    COOL  = 3'd3,
    FAULT = 3'd4
  } st_t;

  st_t st;

  logic [5:0]    raw;
  logic [5:0]    meta;
  logic [5:0]    sync;
  logic [5:0]    deb;
  logic [DW-1:0] dcnt [6];

  assign raw = {H, M, L, Ua, Us, T};

  // Debounce counter tracks how long sync has disagreed with deb
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      deb  <= '0;
      dcnt <= '{default: '0};
    end else begin
      meta <= raw;
      sync <= meta;
      for (int i = 0; i < 6; i++) begin
        if (sync[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_END) begin
          deb[i]  <= sync[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  logic hd, md, ld, uad, usd, td;
  logic err, alm, drip_req, spray_req, run_req;

  assign {hd, md, ld, uad, usd, td} = deb;

  assign err       = (hd & ~md) | (md & ~ld);
  assign alm       = err | ~ld;
  assign drip_req  = ~usd & (~uad | (~td & md));
  assign spray_req = ~usd & uad & (td | ~md);
  assign run_req   = (st == DRIP) ? drip_req : spray_req;

  logic [RW-1:0] run_cnt;
  logic [CW-1:0] cool_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      Bs       <= 1'b0;
      Vs       <= 1'b0;
      E        <= 1'b0;
      Al       <= 1'b0;
      tout     <= 1'b0;
      run_cnt  <= '0;
      cool_cnt <= '0;
    end else begin
      E  <= err;
      Al <= alm;
      unique case (st)
        IDLE: begin
          if (alm) begin
            st <= FAULT;
          end else if (drip_req) begin
            st      <= DRIP;
            Bs      <= 1'b1;
            run_cnt <= '0;
            tout    <= 1'b0;
          end else if (spray_req) begin
            st      <= SPRAY;
            Vs      <= 1'b1;
            run_cnt <= '0;
            tout    <= 1'b0;
          end
        end
        DRIP, SPRAY: begin
          if (alm) begin
            st <= FAULT;
            Bs <= 1'b0;
            Vs <= 1'b0;
          end else if (run_cnt == RUN_MAX) begin
            st       <= COOL;
            Bs       <= 1'b0;
            Vs       <= 1'b0;
            tout     <= 1'b1;
            cool_cnt <= '0;
          end else if (run_cnt >= RUN_MIN && !run_req) begin
            st       <= COOL;
            Bs       <= 1'b0;
            Vs       <= 1'b0;
            cool_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        COOL: begin
          if (alm) begin
            st <= FAULT;
          end else if (cool_cnt == COOL_END) begin
            st <= IDLE;
          end else begin
            cool_cnt <= cool_cnt + 1'b1;
          end
        end
        FAULT: begin
          if (!alm) begin
            st <= IDLE;
          end
        end
        default: begin
          st <= FAULT;
          Bs <= 1'b0;
          Vs <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

`ifdef DISP_AUTO_TOGGLE_EN
  localparam int TW = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
  localparam logic [TW-1:0] TOG_END = TW'(DISP_CYC - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt     <= '0;
      disp_sel <= 1'b0;
    end else if (st == FAULT) begin
      tcnt     <= '0;
      disp_sel <= 1'b0;
    end else if (tcnt == TOG_END) begin
      tcnt     <= '0;
      disp_sel <= ~disp_sel;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic s_meta;

  // disp_sel is the second synchronizer flop for S
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_meta   <= 1'b0;
      disp_sel <= 1'b0;
    end else begin
      s_meta   <= S;
      disp_sel <= s_meta;
    end
  end
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed and random bench for irrigation_scheduler with a reference model.
// Model follows sensor delays, debounce windows and run/cool dwell times.
module tb_irrigation_scheduler;

  localparam int DEB   = 4;
  localparam int MINON = 16;
  localparam int MAXON = 64;
  localparam int COOLC = 8;
  localparam int DISPC = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic H = 1'b0, M = 1'b0, L = 1'b0;
  logic Ua = 1'b0, Us = 1'b0, T = 1'b0, S = 1'b0;
  logic Bs, Vs, E, Al, tout, disp_sel;
  logic [2:0] state;

  irrigation_scheduler #(
    .DEB_CYC (DEB),
    .MIN_ON  (MINON),
    .MAX_ON  (MAXON),
    .COOL_CYC(COOLC),
    .DISP_CYC(DISPC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .H       (H),
    .M       (M),
    .L       (L),
    .Ua      (Ua),
    .Us      (Us),
    .T       (T),
    .S       (S),
    .Bs      (Bs),
    .Vs      (Vs),
    .E       (E),
    .Al      (Al),
    .tout    (tout),
    .disp_sel(disp_sel),
    .state   (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [5:0] m_meta, m_sync, m_deb;
  logic [5:0] win[$];
  int         m_st, m_dwell, m_tph;
  logic       m_tout, m_smeta;
  logic       e_bs, e_vs, e_e, e_al, e_disp;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_meta = '0; m_sync = '0; m_deb = '0;
    win.delete();
    m_st = 0; m_dwell = 0; m_tph = 0;
    m_tout = 0; m_smeta = 0;
    e_bs = 0; e_vs = 0; e_e = 0; e_al = 0; e_disp = 0;
  endtask

  task automatic model_step();
    logic hd, md, ld, uad, usd, td;
    logic err, alm, dr, sp, req, same;
    int prev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    {hd, md, ld, uad, usd, td} = m_deb;
    err = (hd & ~md) | (md & ~ld);
    alm = err | ~ld;
    dr  = ~usd & (~uad | (~td & md));
    sp  = ~usd & uad & (td | ~md);
    prev = m_st;
    case (m_st)
      0: begin
        if (alm) begin m_st = 4; m_dwell = 0; end
        else if (dr) begin m_st = 1; m_dwell = 0; m_tout = 0; end
        else if (sp) begin m_st = 2; m_dwell = 0; m_tout = 0; end
      end
      1, 2: begin
        req = (m_st == 1) ? dr : sp;
        if (alm) begin m_st = 4; m_dwell = 0; end
        else if (m_dwell + 1 == MAXON) begin
          m_st = 3; m_dwell = 0; m_tout = 1;
        end
        else if (m_dwell + 1 >= MINON && !req) begin
          m_st = 3; m_dwell = 0;
        end
        else m_dwell++;
      end
      3: begin
        if (alm) begin m_st = 4; m_dwell = 0; end
        else if (m_dwell + 1 == COOLC) begin m_st = 0; m_dwell = 0; end
        else m_dwell++;
      end
      default: begin
        if (!alm) begin m_st = 0; m_dwell = 0; end
      end
    endcase
    e_bs = (m_st == 1);
    e_vs = (m_st == 2);
    e_e  = err;
    e_al = alm;
`ifdef DISP_AUTO_TOGGLE_EN
    if (prev == 4) begin
      e_disp = 0; m_tph = 0;
    end else begin
      m_tph++;
      if (m_tph == DISPC) begin e_disp = ~e_disp; m_tph = 0; end
    end
`else
    e_disp = m_smeta;
    m_smeta = S;
`endif
    // a sensor settles once its last DEB synchronized samples agree
    win.push_back(m_sync);
    if (win.size() > DEB) void'(win.pop_front());
    if (win.size() == DEB) begin
      for (int b = 0; b < 6; b++) begin
        same = 1;
        for (int k = 1; k < DEB; k++)
          if (win[k][b] != win[0][b]) same = 0;
        if (same) m_deb[b] = win[0][b];
      end
    end
    m_sync = m_meta;
    m_meta = {H, M, L, Ua, Us, T};
  endtask

  task automatic compare_all();
    check("Bs", 8'(Bs), 8'(e_bs));
    check("Vs", 8'(Vs), 8'(e_vs));
    check("E", 8'(E), 8'(e_e));
    check("Al", 8'(Al), 8'(e_al));
    check("tout", 8'(tout), 8'(m_tout));
    check("disp_sel", 8'(disp_sel), 8'(e_disp));
    check("state", 8'(state), 8'(m_st));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_state(int target, int budget);
    int n = 0;
    while (state !== 3'(target) && n < budget) begin
      tick();
      n++;
    end
    check("wait_state", 8'(state), 8'(target));
  endtask

  task automatic count_in(int s, int budget, output int n);
    n = 0;
    while (state === 3'(s) && n < budget) begin
      tick();
      n++;
    end
  endtask

  int n;
  int hold;

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_state", 8'(state), 8'd0);
    check("rst_bs", 8'(Bs), 8'd0);

    rst_n = 1;
    tick();
    check("post_rst_fault", 8'(state), 8'd4);

    H = 1; M = 1; L = 1; Us = 0; Ua = 0; T = 0;
    wait_state(1, 30);
    check("fill_drip_bs", 8'(Bs), 8'd1);

    repeat (5) tick();
    Us = 1;
    count_in(1, 100, n);
    check("drip_len", 8'(5 + n), 8'(MINON));
    check("drip_to_cool", 8'(state), 8'd3);
    count_in(3, 100, n);
    check("cool_len", 8'(n), 8'(COOLC));
    check("cool_to_idle", 8'(state), 8'd0);

    Us = 0; Ua = 1; T = 1;
    wait_state(2, 30);
    check("spray_vs", 8'(Vs), 8'd1);
    count_in(2, 200, n);
    check("spray_len", 8'(n), 8'(MAXON));
    check("timeout_flag", 8'(tout), 8'd1);
    check("timeout_cool", 8'(state), 8'd3);
    wait_state(2, 40);
    check("tout_cleared", 8'(tout), 8'd0);

    M = 0;
    wait_state(4, 30);
    check("err_E", 8'(E), 8'd1);
    check("err_Al", 8'(Al), 8'd1);
    check("err_Vs", 8'(Vs), 8'd0);

    M = 1;
    wait_state(2, 40);
    Us = 1;
    wait_state(0, 200);
    L = 0;
    tick();
    tick();
    L = 1;
    repeat (12) begin
      tick();
      check("glitch_state", 8'(state), 8'd0);
      check("glitch_al", 8'(Al), 8'd0);
      check("glitch_e", 8'(E), 8'd0);
    end

    Us = 0; Ua = 0;
    wait_state(1, 30);
    repeat (3) tick();
    rst_n = 0;
    tick();
    check("midrun_rst_bs", 8'(Bs), 8'd0);
    check("midrun_rst_state", 8'(state), 8'd0);
    rst_n = 1;
    tick();
    check("rerelease_fault", 8'(state), 8'd4);

    S = 1;
    repeat (4) tick();
    S = 0;
    repeat (4) tick();

    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 0;
        tick();
        rst_n = 1;
      end
      H  = 1'($urandom_range(0, 1));
      M  = ($urandom_range(0, 3) != 0);
      L  = ($urandom_range(0, 5) != 0);
      Ua = 1'($urandom_range(0, 1));
      Us = ($urandom_range(0, 2) == 0);
      T  = 1'($urandom_range(0, 1));
      S  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(20, 90);
      else hold = $urandom_range(1, 10);
      repeat (hold) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameters SHALL be: DEB_CYC, default 4, sensor debounce length in cycles; MIN_ON, default 16, minimum run cycles; MAX_ON, default 64, run timeout cycles; COOL_CYC, default 8, post-run off time; DISP_CYC, default 32, display toggle period.
REQ-002 clk  in  1  single system clock; all logic on the rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low.
REQ-004 H, M, L  in  1 each  tank level sensors (high/mid/low); asynchronous.
REQ-005 Ua, Us, T  in  1 each  air humidity, soil humidity, temperature flags; asynchronous.
REQ-006 S  in  1  manual display select (0 = tank, 1 = irrigation).
REQ-007 Bs  out  1  drip valve enable.
REQ-008 Vs  out  1  sprinkler valve enable.
REQ-009 E  out  1  level-sensor error.
REQ-010 Al  out  1  alarm.
REQ-011 tout  out  1  sticky run-timeout flag.
REQ-012 disp_sel  out  1  display mux select.
REQ-013 state  out  3  FSM state code: IDLE=0, DRIP=1, SPRAY=2, COOL=3, FAULT=4.

Function
REQ-014 Each sensor input SHALL pass through a 2-flop synchronizer, then a debouncer whose output takes the synchronized value once that value has been stable for DEB_CYC consecutive cycles.
REQ-015 Internal err SHALL be (Hd & ~Md) | (Md & ~Ld); internal alm SHALL be err | ~Ld, where Hd, Md and Ld are debounced values.
REQ-016 drip_req SHALL be ~Usd & (~Uad | (~Td & Md)); spray_req SHALL be ~Usd & Uad & (Td | ~Md); the two are mutually exclusive by construction.
REQ-017 IDLE: if alm, go to FAULT; else if drip_req, go to DRIP; else if spray_req, go to SPRAY; on entry to DRIP or SPRAY, the run counter SHALL clear and tout SHALL clear.
REQ-018 DRIP/SPRAY: the run counter increments every cycle; alm SHALL force FAULT on the next edge, with priority over all other exits.
REQ-019 DRIP/SPRAY exit to COOL SHALL occur when the counter is at least MIN_ON-1 and the state's request is low.
REQ-020 DRIP/SPRAY exit to COOL SHALL also occur when the counter equals MAX_ON-1; on a timeout exit, tout SHALL be set to 1.
REQ-021 A request that changes type mid-run (drip to spray) SHALL NOT switch state directly; the change is served only after COOL and IDLE.
REQ-022 COOL: stays for exactly COOL_CYC cycles, then goes to IDLE; alm SHALL take it to FAULT.
REQ-023 FAULT: stays while alm=1; goes to IDLE on the first cycle alm=0.
REQ-024 Bs SHALL be 1 only in DRIP and Vs only in SPRAY; Bs and Vs SHALL never both be 1.
REQ-025 All outputs SHALL be registered; latency from a debounced change to an output is 1 cycle.
REQ-026 E and Al SHALL be registered copies of err and alm.
REQ-027 Counters SHALL saturate and never wrap; the run counter width SHALL be clog2(MAX_ON).

Reset
REQ-028 When rst_n=0 at a clock edge, state SHALL go to IDLE; Bs, Vs, E, Al, tout and disp_sel SHALL go to 0; all counters SHALL go to 0.
REQ-029 On that same reset edge, synchronizers and debounced values SHALL go to 0.
REQ-030 Because reset leaves Ld=0, the FSM SHALL enter FAULT on the first edge after reset release, and SHALL leave FAULT only after the level sensors debounce to a valid level.
REQ-031 Reset asserted mid-run SHALL drop Bs and Vs on that same edge.

Configuration
REQ-032 Macro DISP_AUTO_TOGGLE_EN SHALL select how disp_sel is driven.
REQ-033 With DISP_AUTO_TOGGLE_EN defined, disp_sel SHALL invert every DISP_CYC cycles, S SHALL be ignored, and disp_sel SHALL be forced to 0 while in FAULT.
REQ-034 Without DISP_AUTO_TOGGLE_EN, disp_sel SHALL be the 2-flop-synchronized S and no toggle counter SHALL be built.

Verification
REQ-035 Fill to H=M=L=1 with Us=0, Ua=0 -> FAULT, then IDLE after 2+DEB_CYC cycles, then DRIP (Bs=1) on the next edge.
REQ-036 In DRIP, raise Us=1 at run count 5 -> Bs stays 1 until the count reaches 15, then COOL for 8 cycles, then IDLE.
REQ-037 Hold Us=0, Ua=1, T=1 -> SPRAY (Vs=1) for exactly 64 cycles, then tout=1 and COOL; the next run start clears tout.
REQ-038 During SPRAY, set H=1, M=0 (debounced) -> E=1 and Al=1, Vs=0 one cycle later, state=4.
REQ-039 Toggle L with a 2-cycle glitch -> no change on E, Al or state.
REQ-040 Assert rst_n=0 mid-DRIP -> Bs=0 and state=0 at that edge; with DISP_AUTO_TOGGLE_EN, disp_sel toggles every 32 cycles outside FAULT.
